// File: rtl/level_loader_pkg.sv
// level_loader_pkg: shared defaults, state encoding and coordinate helper.
// Used by level_loader and level_rom.
package level_loader_pkg;

    localparam int BRICKNUM = 128;
    localparam int HP_W_DEF = 10;
    localparam int COORD_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAW  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [COORD_W-1:0] slot_coord(
        input int org,
        input int pitch,
        input int n
    );
        return COORD_W'(org + n * pitch);
    endfunction

endpackage

// File: rtl/level_rom.sv
// level_rom: per-level brick health maps behind one registered read port.
// Unlisted slots and out-of-range levels return an empty brick.
module level_rom
    import level_loader_pkg::*;
#(
    parameter int LEVELS = 4,
    parameter int LVL_W  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en_i,
    input  logic [LVL_W-1:0]   level_i,
    input  logic [COORD_W-1:0] index_i,
    output logic [1:0]         health_o
);

    logic [1:0] hp_d;
    logic [1:0] hp_q;

    always_comb begin
        hp_d = 2'd0;
        if (int'(level_i) < LEVELS) begin
            case (int'(level_i))
                0: case (index_i)
                    10'd0:   hp_d = 2'd1;
                    10'd5:   hp_d = 2'd2;
                    10'd17:  hp_d = 2'd3;
                    10'd20:  hp_d = 2'd1;
                    10'd40:  hp_d = 2'd2;
                    10'd63:  hp_d = 2'd3;
                    10'd100: hp_d = 2'd2;
                    10'd127: hp_d = 2'd1;
                    default: hp_d = 2'd0;
                endcase
                1: case (index_i)
                    10'd1:   hp_d = 2'd1;
                    10'd2:   hp_d = 2'd2;
                    10'd3:   hp_d = 2'd3;
                    default: hp_d = 2'd0;
                endcase
                2: case (index_i)
                    10'd10:  hp_d = 2'd2;
                    10'd11:  hp_d = 2'd2;
                    10'd40:  hp_d = 2'd3;
                    10'd90:  hp_d = 2'd1;
                    10'd126: hp_d = 2'd3;
                    default: hp_d = 2'd0;
                endcase
                3: case (index_i)
                    10'd7:   hp_d = 2'd3;
                    default: hp_d = 2'd0;
                endcase
                default: hp_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hp_q <= 2'd0;
        end else if (en_i) begin
            hp_q <= hp_d;
        end
    end

    assign health_o = hp_q;

endmodule

// File: rtl/level_loader.sv
// level_loader: walks a level's brick slots, draws each, writes brick RAM.
// Define LOADER_SKIP_EMPTY_EN to let empty slots bypass the draw handshake.
module level_loader
    import level_loader_pkg::*;
#(
    parameter int BRICK_NUM  = BRICKNUM,
    parameter int COLS_LOG2  = 4,
    parameter int BRICK_W    = 10,
    parameter int BRICK_H    = 5,
    parameter int X_ORG      = 0,
    parameter int Y_ORG      = 0,
    parameter int LEVELS     = 4,
    parameter int HP_W       = HP_W_DEF,
    parameter int AUTO_START = 1,
    parameter int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [LVL_W-1:0]   level_sel,
    input  logic               draw_done,
    output logic               draw_req,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COORD_W-1:0] address,
    output logic [1:0]         health,
    output logic               writeEn,
    output logic [HP_W-1:0]    total_health,
    output logic               busy,
    output logic               done
);

    state_t               state_q;
    logic [COORD_W-1:0]   index_q;
    logic [LVL_W-1:0]     level_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic                 req_q;
    logic                 wr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 auto_q;
    logic [HP_W-1:0]      sum_q;

    logic                 accept;
    logic                 last;
    logic                 rom_en;
    logic [LVL_W-1:0]     lvl_d;
    logic [LVL_W-1:0]     rom_lvl;
    logic [COORD_W-1:0]   rom_idx;
    logic [1:0]           hp;
    logic [HP_W:0]        sum_wide;

    // ROM is addressed with the next index so its output lines up with FETCH.
    always_comb begin
        accept   = (state_q == S_IDLE || state_q == S_DONE) && (start || auto_q);
        last     = (index_q == COORD_W'(BRICK_NUM - 1));
        lvl_d    = (start && int'(level_sel) < LEVELS) ? level_sel : '0;
        rom_en   = accept || (state_q == S_WRITE && !last);
        rom_idx  = accept ? '0 : index_q + 1'b1;
        rom_lvl  = accept ? lvl_d : level_q;
        sum_wide = {1'b0, sum_q} + (HP_W + 1)'(hp);
    end

    level_rom #(
        .LEVELS (LEVELS),
        .LVL_W  (LVL_W)
    ) u_rom (
        .clk      (clk),
        .resetn   (resetn),
        .en_i     (rom_en),
        .level_i  (rom_lvl),
        .index_i  (rom_idx),
        .health_o (hp)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            index_q <= '0;
            level_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            auto_q  <= (AUTO_START != 0);
        end else begin
            if (rom_en) begin
                x_q <= slot_coord(X_ORG, BRICK_W,
                                  int'(rom_idx) % (1 << COLS_LOG2));
                y_q <= slot_coord(Y_ORG, BRICK_H,
                                  int'(rom_idx) >> COLS_LOG2);
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_q <= S_FETCH;
                        level_q <= lvl_d;
                        index_q <= '0;
                        sum_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        auto_q  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DRAW;
                    req_q   <= 1'b1;
`ifdef LOADER_SKIP_EMPTY_EN
                    if (hp == 2'd0) begin
                        state_q <= S_WRITE;
                        req_q   <= 1'b0;
                        wr_q    <= 1'b1;
                    end
`endif
                end
                S_DRAW: begin
                    if (draw_done) begin
                        state_q <= S_WRITE;
                        req_q   <= 1'b0;
                        wr_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    wr_q  <= 1'b0;
                    sum_q <= sum_wide[HP_W] ? '1 : sum_wide[HP_W-1:0];
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        index_q <= index_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign draw_req     = req_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign address      = index_q;
    assign health       = hp;
    assign writeEn      = wr_q;
    assign total_health = sum_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_level_loader.sv
// tb_level_loader: scoreboard bench for level_loader (default parameters).
// Expected brick writes are queued by stimulus and popped by a monitor.
module tb_level_loader;

    typedef struct packed {
        logic [9:0] a;
        logic [1:0] h;
    } wr_t;

`ifdef LOADER_SKIP_EMPTY_EN
    localparam int L0_REQS = 8;
`else
    localparam int L0_REQS = 128;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] level_sel;
    logic       draw_done;
    logic       draw_req;
    logic [9:0] x_out;
    logic [9:0] y_out;
    logic [9:0] address;
    logic [1:0] health;
    logic       writeEn;
    logic [9:0] total_health;
    logic       busy;
    logic       done;

    int  checks   = 0;
    int  failures = 0;
    int  dly      = 2;
    int  rcnt     = 0;
    int  req_cnt  = 0;
    int  wr_cnt   = 0;
    bit  req_prev = 1'b0;
    bit  xy_arm   = 1'b0;
    wr_t exp_q[$];

    level_loader dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .level_sel    (level_sel),
        .draw_done    (draw_done),
        .draw_req     (draw_req),
        .x_out        (x_out),
        .y_out        (y_out),
        .address      (address),
        .health       (health),
        .writeEn      (writeEn),
        .total_health (total_health),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Hand-written level maps (slot -> health); unlisted slots are empty.
    function automatic logic [1:0] exp_hp(input int lv, input int i);
        logic [1:0] h;
        h = 2'd0;
        case (lv)
            0: case (i)
                0: h = 1; 5: h = 2; 17: h = 3; 20: h = 1;
                40: h = 2; 63: h = 3; 100: h = 2; 127: h = 1;
                default: h = 0;
            endcase
            1: case (i)
                1: h = 1; 2: h = 2; 3: h = 3;
                default: h = 0;
            endcase
            2: case (i)
                10: h = 2; 11: h = 2; 40: h = 3; 90: h = 1; 126: h = 3;
                default: h = 0;
            endcase
            default: h = 0;
        endcase
        return h;
    endfunction

    task automatic push_level(input int lv);
        for (int i = 0; i < 128; i++)
            exp_q.push_back({10'(i), exp_hp(lv, i)});
    endtask

    task automatic pulse_start(input logic [1:0] lv);
        @(negedge clk);
        start     = 1'b1;
        level_sel = lv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
    endtask

    // Draw engine model: pulses draw_done dly cycles after draw_req rises.
    initial begin
        draw_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn || draw_done) begin
                draw_done = 1'b0;
                rcnt      = 0;
            end else if (draw_req) begin
                rcnt++;
                if (rcnt >= dly) draw_done = 1'b1;
            end
        end
    end

    // Monitor: counts requests, checks slot coordinates, pops write scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (draw_req && !req_prev) begin
                req_cnt++;
                if (xy_arm) begin
                    case (address)
                        10'd17:  chk("xy_slot17", {x_out, y_out}, {10'd10, 10'd5});
                        10'd40:  chk("xy_slot40", {x_out, y_out}, {10'd80, 10'd10});
                        10'd127: chk("xy_slot127", {x_out, y_out}, {10'd150, 10'd35});
                        default: ;
                    endcase
                end
            end
            req_prev = draw_req;
            if (writeEn) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(address), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(address), 32'(e.a));
                    chk("wr_health", 32'(health), 32'(e.h));
                end
            end
        end
    end

    initial begin
        int r0, w0, n;
        logic [31:0] cap;
        bit bad;
        resetn    = 1'b0;
        start     = 1'b0;
        level_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs",
            {draw_req, writeEn, busy, done, x_out, y_out, address, health},
            32'd0);
        chk("reset_total", 32'(total_health), 32'd0);

        // Auto-started load of level 0.
        push_level(0);
        r0 = req_cnt;
        w0 = wr_cnt;
        xy_arm = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        wait_done("l0");
        xy_arm = 1'b0;
        chk("l0_total", 32'(total_health), 32'd15);
        chk("l0_busy", 32'(busy), 32'd0);
        chk("l0_writes", 32'(wr_cnt - w0), 32'd128);
        chk("l0_reqs", 32'(req_cnt - r0), 32'(L0_REQS));
        chk("l0_queue", 32'(exp_q.size()), 32'd0);

        // Level 1 with a stalled draw engine and a start pulse mid-load.
        dly = 50;
        push_level(1);
        pulse_start(2'd1);
        chk("acc1_total", 32'(total_health), 32'd0);
        chk("acc1_flags", {busy, done}, 32'b10);
        n = 0;
        while (!draw_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_req", 32'(draw_req), 32'd1);
        cap = {2'b0, x_out, y_out, address};
        chk("stall_health", 32'(health), 32'(exp_hp(1, int'(address))));
        pulse_start(2'd3);
        bad = 1'b0;
        repeat (38) begin
            @(posedge clk);
            #1;
            if (!draw_req || writeEn || {2'b0, x_out, y_out, address} != cap)
                bad = 1'b1;
        end
        chk("stall_stable", 32'(bad), 32'd0);
        dly = 2;
        wait_done("l1");
        chk("l1_total", 32'(total_health), 32'd6);
        chk("l1_queue", 32'(exp_q.size()), 32'd0);

        // Restart from DONE with level 2; reset lands in the draw of slot 40.
        push_level(2);
        pulse_start(2'd2);
        chk("acc2_total", 32'(total_health), 32'd0);
        chk("acc2_addr", 32'(address), 32'd0);
        chk("acc2_flags", {busy, done}, 32'b10);
        n = 0;
        while (!(draw_req && address == 10'd40) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("slot40_reached", 32'(draw_req && address == 10'd40), 32'd1);
        chk("slot40_health", 32'(health), 32'd3);
        chk("l2_partial", 32'(total_health), 32'd4);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_outs",
            {draw_req, writeEn, busy, done, x_out, y_out, address, health},
            32'd0);
        chk("rst_mid_total", 32'(total_health), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_we", 32'(writeEn), 32'd0);
        exp_q.delete();

        // Auto start again after the reset releases.
        push_level(0);
        r0 = req_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        resetn = 1'b1;
        wait_done("l0b");
        chk("l0b_total", 32'(total_health), 32'd15);
        chk("l0b_writes", 32'(wr_cnt - w0), 32'd128);
        chk("l0b_reqs", 32'(req_cnt - r0), 32'(L0_REQS));
        chk("l0b_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
